// File: rtl/conv_job_sequencer_pkg.sv
// Shared definitions for the conv job sequencer: one-hot state encoding,
// header/dim constants, error codes and the header decode helper.
package conv_job_sequencer_pkg;

    typedef enum logic [7:0] {
        ST_IDLE    = 8'b0000_0001,
        ST_FETCH   = 8'b0000_0010,
        ST_WAIT_RD = 8'b0000_0100,
        ST_DECODE  = 8'b0000_1000,
        ST_LAUNCH  = 8'b0001_0000,
        ST_RUN     = 8'b0010_0000,
        ST_DONE    = 8'b0100_0000,
        ST_ERR     = 8'b1000_0000
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BAD_DIM  = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_OVERFLOW = 2'd3
    } err_code_e;

    localparam logic [1:0]  DIM_CODE_10 = 2'b00;
    localparam logic [1:0]  DIM_CODE_12 = 2'b01;
    localparam logic [1:0]  DIM_CODE_16 = 2'b10;
    localparam logic [15:0] HDR_TERM    = 16'h00FF;

    typedef struct packed {
        logic       valid;
        logic [1:0] code;
        logic [4:0] words;
    } dim_info_t;

    function automatic dim_info_t decode_dim(input logic [15:0] hdr);
        dim_info_t info;
        case (hdr)
            16'd10:  info = '{valid: 1'b1, code: DIM_CODE_10, words: 5'd10};
            16'd12:  info = '{valid: 1'b1, code: DIM_CODE_12, words: 5'd12};
            16'd16:  info = '{valid: 1'b1, code: DIM_CODE_16, words: 5'd16};
            default: info = '{valid: 1'b0, code: DIM_CODE_10, words: 5'd0};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/conv_job_sequencer_launch_timer.sv
// Launch watchdog: loaded before LAUNCH, counts down while in LAUNCH and
// flags expiry in the last cycle the engine is allowed to answer.
module conv_launch_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset_b,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_r;

    // Down-counter; expired rises in the cycle where count reaches one
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            count_r <= {CW{1'b0}};
            expired <= 1'b0;
        end else if (load) begin
            count_r <= CW'(TIMEOUT);
            expired <= (TIMEOUT == 1);
        end else if (en && (count_r != {CW{1'b0}})) begin
            count_r <= count_r - CW'(1);
            expired <= (count_r == CW'(2));
        end else begin
            count_r <= count_r;
            expired <= expired;
        end
    end

endmodule

// File: rtl/conv_job_sequencer.sv
// Walks the packed image stream in SRAM and launches the conv engine per image.
// Optional JOB_STATS_EN adds saturating job / busy-cycle counters.
module conv_job_sequencer
    import conv_job_sequencer_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 16,
    parameter int LAUNCH_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              seq_start,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              seq_err,
    output logic [1:0]        seq_err_code,
    output logic [ADDR_W-1:0] sram_read_address,
    input  logic [DATA_W-1:0] sram_read_data,
    input  logic [ADDR_W-1:0] eng_sram_read_address,
    output logic              eng_run,
    input  logic              eng_busy,
    output logic [ADDR_W-1:0] eng_src_base,
    output logic [ADDR_W-1:0] eng_dst_base,
    output logic [1:0]        eng_dim
`ifdef JOB_STATS_EN
    ,
    output logic [7:0]        stat_jobs,
    output logic [15:0]       stat_cycles
`endif
);

    state_e            state_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W:0]   rd_sum_s;
    logic [ADDR_W:0]   wr_sum_s;
    dim_info_t         dim_s;
    logic              is_term_s;
    logic              ovf_s;
    logic              launch_ok_s;
    logic              seq_port_s;
    logic              tmr_expired_s;

    // Header decode and next-pointer arithmetic with a carry bit for overflow
    always_comb begin
        dim_s       = decode_dim(sram_read_data);
        is_term_s   = (sram_read_data == DATA_W'(HDR_TERM));
        rd_sum_s    = {1'b0, rd_ptr_r} + {{(ADDR_W-4){1'b0}}, dim_s.words}
                      + {{ADDR_W{1'b0}}, 1'b1};
        wr_sum_s    = {1'b0, wr_ptr_r} + {{(ADDR_W-4){1'b0}}, dim_s.words}
                      - {{(ADDR_W-1){1'b0}}, 2'd2};
        ovf_s       = rd_sum_s[ADDR_W] | wr_sum_s[ADDR_W];
        launch_ok_s = (state_r == ST_DECODE) && !is_term_s && dim_s.valid && !ovf_s;
    end

    // The sequencer owns the read port only while fetching a header
    assign seq_port_s        = (state_r == ST_FETCH) || (state_r == ST_WAIT_RD)
                               || (state_r == ST_DECODE);
    assign sram_read_address = seq_port_s ? rd_ptr_r : eng_sram_read_address;

    conv_launch_timer #(
        .TIMEOUT (LAUNCH_TIMEOUT)
    ) u_launch_timer (
        .clk     (clk),
        .reset_b (reset_b),
        .load    (state_r == ST_DECODE),
        .en      (state_r == ST_LAUNCH),
        .expired (tmr_expired_s)
    );

    // Main sequencer FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_r      <= ST_IDLE;
            rd_ptr_r     <= {ADDR_W{1'b0}};
            wr_ptr_r     <= {ADDR_W{1'b0}};
            seq_busy     <= 1'b0;
            seq_done     <= 1'b0;
            seq_err      <= 1'b0;
            seq_err_code <= ERR_NONE;
            eng_run      <= 1'b0;
            eng_src_base <= {ADDR_W{1'b0}};
            eng_dst_base <= {ADDR_W{1'b0}};
            eng_dim      <= DIM_CODE_10;
        end else begin
            seq_done <= 1'b0;
            seq_err  <= 1'b0;
            eng_run  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (seq_start) begin
                        rd_ptr_r     <= {ADDR_W{1'b0}};
                        wr_ptr_r     <= {ADDR_W{1'b0}};
                        seq_err_code <= ERR_NONE;
                        seq_busy     <= 1'b1;
                        state_r      <= ST_FETCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH:   state_r <= ST_WAIT_RD;
                ST_WAIT_RD: state_r <= ST_DECODE;
                ST_DECODE: begin
                    if (is_term_s) begin
                        seq_done <= 1'b1;
                        state_r  <= ST_DONE;
                    end else if (!dim_s.valid) begin
                        seq_err      <= 1'b1;
                        seq_err_code <= ERR_BAD_DIM;
                        state_r      <= ST_ERR;
                    end else if (ovf_s) begin
                        seq_err      <= 1'b1;
                        seq_err_code <= ERR_OVERFLOW;
                        state_r      <= ST_ERR;
                    end else begin
                        eng_src_base <= rd_ptr_r;
                        eng_dst_base <= wr_ptr_r;
                        eng_dim      <= dim_s.code;
                        rd_ptr_r     <= rd_sum_s[ADDR_W-1:0];
                        wr_ptr_r     <= wr_sum_s[ADDR_W-1:0];
                        eng_run      <= 1'b1;
                        state_r      <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (eng_busy) begin
                        state_r <= ST_RUN;
                    end else if (tmr_expired_s) begin
                        seq_err      <= 1'b1;
                        seq_err_code <= ERR_TIMEOUT;
                        state_r      <= ST_ERR;
                    end else begin
                        state_r <= ST_LAUNCH;
                    end
                end
                ST_RUN: begin
                    if (!eng_busy) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE, ST_ERR: begin
                    seq_busy <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    seq_busy <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef JOB_STATS_EN
    // Saturating statistics, cleared by an accepted start and held after exit
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            stat_jobs   <= 8'd0;
            stat_cycles <= 16'd0;
        end else if ((state_r == ST_IDLE) && seq_start) begin
            stat_jobs   <= 8'd0;
            stat_cycles <= 16'd0;
        end else begin
            if (launch_ok_s && (stat_jobs != 8'hFF)) begin
                stat_jobs <= stat_jobs + 8'd1;
            end
            if (seq_busy && (stat_cycles != 16'hFFFF)) begin
                stat_cycles <= stat_cycles + 16'd1;
            end
        end
    end
`else
    // Statistics are compiled out in this build.
`endif

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Directed bench for conv_job_sequencer: table of single-header streams plus
// hand-written multi-cycle sequences (timeout, port mux, stale busy, reset, overflow).
module tb_conv_job_sequencer;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset_b = 1'b1;
    logic              seq_start = 1'b0;
    logic              seq_busy, seq_done, seq_err, eng_run, eng_busy;
    logic [1:0]        seq_err_code, eng_dim;
    logic [ADDR_W-1:0] sram_read_address, eng_src_base, eng_dst_base;
    logic [ADDR_W-1:0] eng_addr = 12'h000;
    logic [DATA_W-1:0] sram_read_data = 16'h0000;
`ifdef JOB_STATS_EN
    logic [7:0]        stat_jobs;
    logic [15:0]       stat_cycles;
`endif

    conv_job_sequencer dut (
        .clk                   (clk),
        .reset_b               (reset_b),
        .seq_start             (seq_start),
        .seq_busy              (seq_busy),
        .seq_done              (seq_done),
        .seq_err               (seq_err),
        .seq_err_code          (seq_err_code),
        .sram_read_address     (sram_read_address),
        .sram_read_data        (sram_read_data),
        .eng_sram_read_address (eng_addr),
        .eng_run               (eng_run),
        .eng_busy              (eng_busy),
        .eng_src_base          (eng_src_base),
        .eng_dst_base          (eng_dst_base),
        .eng_dim               (eng_dim)
`ifdef JOB_STATS_EN
        ,
        .stat_jobs             (stat_jobs),
        .stat_cycles           (stat_cycles)
`endif
    );

    always #5 clk = ~clk;

    // SRAM with one-cycle read latency
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) sram_read_data <= mem[sram_read_address];

    // Engine model: busy for eng_len cycles starting eng_lat cycles after eng_run
    logic eng_respond = 1'b1;
    logic force_busy  = 1'b0;
    int   eng_lat = 1, eng_len = 3, eng_ctr = 0;
    always @(posedge clk) begin
        if (eng_run && eng_respond) eng_ctr <= eng_lat + eng_len;
        else if (eng_ctr > 0)       eng_ctr <= eng_ctr - 1;
    end
    assign eng_busy = force_busy | ((eng_ctr > 0) && (eng_ctr <= eng_len));

    // Event logs: launches, header fetch addresses, exit pulses
    int                nrun = 0, nseqa = 0, nerr = 0, cyc = 0, run_cyc = 0, err_cyc = 0;
    logic [ADDR_W-1:0] run_src [0:511];
    logic [ADDR_W-1:0] run_dst [0:511];
    logic [1:0]        run_dim [0:511];
    logic [ADDR_W-1:0] seqa    [0:511];
    logic              prev_own = 1'b1;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_own <= (sram_read_address == eng_addr);
        if (eng_run) begin
            run_src[nrun % 512] <= eng_src_base;
            run_dst[nrun % 512] <= eng_dst_base;
            run_dim[nrun % 512] <= eng_dim;
            run_cyc             <= cyc;
            nrun                <= nrun + 1;
        end
        if ((sram_read_address != eng_addr) && prev_own) begin
            seqa[nseqa % 512] <= sram_read_address;
            nseqa             <= nseqa + 1;
        end
        if (seq_err) begin
            err_cyc <= cyc;
            nerr    <= nerr + 1;
        end
    end

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic start_pulse();
        @(negedge clk) seq_start = 1'b1;
        @(negedge clk) seq_start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit fin);
        fin = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (seq_done || seq_err) begin
                fin = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [15:0] hdr;
        logic        exp_done;
        logic [1:0]  exp_code;
        int          exp_runs;
        logic [1:0]  exp_dim;
        int          exp_next;
    } vec_t;

    vec_t vecs [8];
    bit   fin;
    int   base_run, base_seq, base_err;

    initial begin
        vecs[0] = '{16'd10,    1'b1, 2'd0, 1, 2'b00, 11};
        vecs[1] = '{16'h0009,  1'b0, 2'd1, 0, 2'b00, 0};
        vecs[2] = '{16'd12,    1'b1, 2'd0, 1, 2'b01, 13};
        vecs[3] = '{16'h0000,  1'b0, 2'd1, 0, 2'b00, 0};
        vecs[4] = '{16'd16,    1'b1, 2'd0, 1, 2'b10, 17};
        vecs[5] = '{16'h00FF,  1'b1, 2'd0, 0, 2'b00, 0};
        vecs[6] = '{16'd11,    1'b0, 2'd1, 0, 2'b00, 0};
        vecs[7] = '{16'h010A,  1'b0, 2'd1, 0, 2'b00, 0};
        for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 16'h0000;

        // Power-on reset: every output low
        #1 reset_b = 1'b0;
        #1;
        check("rst_busy", seq_busy, 0);
        check("rst_outs", {seq_done, seq_err, seq_err_code, eng_run, eng_dim}, 0);
        check("rst_bases", {eng_src_base, eng_dst_base}, 0);
        check("rst_addr", sram_read_address, 0);
        repeat (3) @(negedge clk);
        reset_b  = 1'b1;
        eng_addr = 12'h123;
        repeat (2) @(negedge clk);

        // Table: one header (plus terminator when valid) at address 0
        for (int v = 0; v < 8; v++) begin
            for (int a = 0; a < 64; a++) mem[a] = 16'h0000;
            mem[0] = vecs[v].hdr;
            if (vecs[v].exp_runs > 0) mem[vecs[v].exp_next] = 16'h00FF;
            base_run = nrun;
            base_seq = nseqa;
            start_pulse();
            wait_end(200, fin);
            check($sformatf("v%0d_finished", v), fin, 1);
            check($sformatf("v%0d_done", v), seq_done, vecs[v].exp_done);
            check($sformatf("v%0d_err", v), seq_err, !vecs[v].exp_done);
            check($sformatf("v%0d_code", v), seq_err_code, vecs[v].exp_code);
            check($sformatf("v%0d_busy_exit", v), seq_busy, 1);
            check($sformatf("v%0d_runs", v), nrun - base_run, vecs[v].exp_runs);
            check($sformatf("v%0d_fetch0", v), seqa[base_seq % 512], 0);
            if (vecs[v].exp_runs > 0) begin
                check($sformatf("v%0d_dim", v), run_dim[base_run % 512], vecs[v].exp_dim);
                check($sformatf("v%0d_src", v), run_src[base_run % 512], 0);
                check($sformatf("v%0d_dst", v), run_dst[base_run % 512], 0);
                check($sformatf("v%0d_next_hdr", v), seqa[(base_seq + 1) % 512], vecs[v].exp_next);
            end
            @(negedge clk);
            check($sformatf("v%0d_busy_after", v), seq_busy, 0);
            check($sformatf("v%0d_pulse_after", v), {seq_done, seq_err}, 0);
        end

        // Back-to-back 16, 12, 10 images
        for (int a = 0; a < 64; a++) mem[a] = 16'h0000;
        mem[0] = 16'd16; mem[17] = 16'd12; mem[30] = 16'd10; mem[41] = 16'h00FF;
        base_run = nrun;
        base_seq = nseqa;
        start_pulse();
        wait_end(300, fin);
        check("b2b_done", {fin, seq_done, seq_err}, 3'b110);
        check("b2b_runs", nrun - base_run, 3);
        check("b2b_src", {run_src[base_run % 512], run_src[(base_run + 1) % 512], run_src[(base_run + 2) % 512]},
              {12'd0, 12'd17, 12'd30});
        check("b2b_dst", {run_dst[base_run % 512], run_dst[(base_run + 1) % 512], run_dst[(base_run + 2) % 512]},
              {12'd0, 12'd14, 12'd24});
        check("b2b_dim", {run_dim[base_run % 512], run_dim[(base_run + 1) % 512], run_dim[(base_run + 2) % 512]},
              6'b10_01_00);
        check("b2b_term_addr", seqa[(base_seq + 3) % 512], 41);
        @(negedge clk);

        // Launch timeout: engine never answers
        eng_respond = 1'b0;
        for (int a = 0; a < 64; a++) mem[a] = 16'h0000;
        mem[0] = 16'd10; mem[11] = 16'h00FF;
        base_run = nrun;
        start_pulse();
        wait_end(100, fin);
        check("to_err", {fin, seq_err}, 2'b11);
        check("to_code", seq_err_code, 2);
        @(negedge clk);
        check("to_latency", err_cyc - run_cyc, 8);
        check("to_runs", nrun - base_run, 1);
        repeat (3) @(negedge clk);
        check("to_code_held", seq_err_code, 2);
        eng_respond = 1'b1;

        // Port mux during RUN, and start ignored while busy
        eng_len  = 20;
        base_run = nrun;
        base_seq = nseqa;
        start_pulse();
        for (int i = 0; i < 50 && nrun == base_run; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("mux_run_eng", sram_read_address, 12'h123);
        eng_addr = 12'h3C5;
        #1 check("mux_run_eng2", sram_read_address, 12'h3C5);
        eng_addr = 12'h123;
        seq_start = 1'b1;
        @(negedge clk) seq_start = 1'b0;
        wait_end(200, fin);
        check("mux_done", {fin, seq_done}, 2'b11);
        check("mux_runs", nrun - base_run, 1);
        check("mux_fetches", nseqa - base_seq, 2);
        check("mux_fetch_addrs", {seqa[base_seq % 512], seqa[(base_seq + 1) % 512]}, {12'd0, 12'd11});
        repeat (2) @(negedge clk);

        // Stale engine busy during fetch/decode is harmless
        eng_len    = 3;
        force_busy = 1'b1;
        base_run   = nrun;
        base_err   = nerr;
        start_pulse();
        repeat (10) @(negedge clk);
        check("stale_busy_high", seq_busy, 1);
        check("stale_no_err", nerr - base_err, 0);
        force_busy = 1'b0;
        wait_end(100, fin);
        check("stale_done", {fin, seq_done, seq_err}, 3'b110);
        check("stale_runs", nrun - base_run, 1);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of the second image's RUN
        eng_len = 20;
        for (int a = 0; a < 64; a++) mem[a] = 16'h0000;
        mem[0] = 16'd16; mem[17] = 16'd12; mem[30] = 16'd10; mem[41] = 16'h00FF;
        base_run = nrun;
        start_pulse();
        for (int i = 0; i < 200 && (nrun - base_run) < 2; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("pre_rst_src", {eng_src_base, eng_dim}, {12'd17, 2'b01});
        eng_addr = 12'h000;
        #2 reset_b = 1'b0;
        #1;
        check("mid_rst_busy", seq_busy, 0);
        check("mid_rst_outs", {seq_done, seq_err, seq_err_code, eng_run, eng_dim}, 0);
        check("mid_rst_bases", {eng_src_base, eng_dst_base, sram_read_address}, 0);
        @(negedge clk);
        reset_b  = 1'b1;
        eng_addr = 12'h123;
        for (int i = 0; i < 40 && eng_ctr != 0; i++) @(negedge clk);
        base_run = nrun;
        base_seq = nseqa;
        start_pulse();
        wait_end(400, fin);
        check("restart_done", {fin, seq_done}, 2'b11);
        check("restart_runs", nrun - base_run, 3);
        check("restart_src", {run_src[base_run % 512], run_src[(base_run + 2) % 512]}, {12'd0, 12'd30});
        check("restart_fetch0", seqa[base_seq % 512], 0);
        repeat (2) @(negedge clk);

        // Address overflow: headers of 16 at 17*j until rd_ptr would pass 4095
        eng_lat = 1;
        eng_len = 1;
        for (int a = 0; a < 64; a++) mem[a] = 16'h0000;
        for (int j = 0; j <= 240; j++) mem[17 * j] = 16'd16;
        base_run = nrun;
        start_pulse();
        wait_end(4000, fin);
        check("ovf_err", {fin, seq_err, seq_done}, 3'b110);
        check("ovf_code", seq_err_code, 3);
        check("ovf_runs", nrun - base_run, 240);
        check("ovf_last_src", run_src[(base_run + 239) % 512], 4063);
        check("ovf_last_dst", run_dst[(base_run + 239) % 512], 3346);
        check("ovf_last_hdr", seqa[(nseqa - 1) % 512], 4080);
        @(negedge clk);
        check("ovf_busy_after", seq_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
